// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin share of one SRAM-like port between IF and EX/MEM, one outstanding transaction
module mem_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [3:0]        wstrb,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state;
  logic owner, last_grant, gnt;
  // owner/grant encoding: 0 = inst, 1 = data; contention goes to whoever was not granted last
  assign gnt = data_req & (~inst_req | ~last_grant);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      wr         <= 1'b0;
      size       <= '0;
      wstrb      <= '0;
      addr       <= '0;
      wdata      <= '0;
    end else begin
      case (state)
        IDLE: if (inst_req || data_req) begin
          owner      <= gnt;
          last_grant <= gnt;
          wr         <= gnt ? data_wr    : inst_wr;
          size       <= gnt ? data_size  : inst_size;
          wstrb      <= gnt ? data_wstrb : inst_wstrb;
          addr       <= gnt ? data_addr  : inst_addr;
          wdata      <= gnt ? data_wdata : inst_wdata;
          state      <= REQ;
        end
        REQ:     if (addr_ok) state <= RESP;
        RESP:    if (data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign req          = state == REQ;
  assign inst_addr_ok = req & ~owner & addr_ok;
  assign data_addr_ok = req &  owner & addr_ok;
  assign inst_data_ok = (state == RESP) & ~owner & data_ok;
  assign data_data_ok = (state == RESP) &  owner & data_ok;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
endmodule
